// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: robot-side UART command endpoint.
// Receives 16-bit commands as two bytes (high byte first) and presents them with
// a cmd_rdy/clr_cmd_rdy handshake; serialises single-byte responses back.
// Optional build macro: CMD_TIMEOUT_EN -- discards a lone high byte after
// TIMEOUT_CYC clocks without a following low byte.
module uart_cmd_responder #(
    parameter int unsigned BAUD_DIV    = 434,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam logic [11:0] BIT_RELOAD  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

    if (BAUD_DIV < 8 || BAUD_DIV > 4095 || TIMEOUT_CYC == 0) begin : g_bad_params
        $error("uart_cmd_responder: BAUD_DIV or TIMEOUT_CYC out of range");
    end

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;

    rx_state_t  rx_state;
    tx_state_t  tx_state;
    asm_state_t asm_state;

    logic        rx_meta, rx_sync, rx_prev;
    logic        rx_start;
    logic [11:0] rx_baud;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        byte_vld;

    logic [7:0]  high_byte;
    logic        cmd_set;
    logic        timeout;

    logic [11:0] tx_baud;
    logic [3:0]  tx_bit;
    logic [9:0]  tx_shift;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_start = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

    // Receiver: sample start, 8 data bits LSB first and stop at bit centres
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_start) begin
                        rx_state <= RX_RECV;
                        rx_baud  <= HALF_RELOAD;
                        rx_bit   <= '0;
                    end
                end
                RX_RECV: begin
                    if (rx_baud != '0) begin
                        rx_baud <= rx_baud - 1'b1;
                    end else begin
                        rx_baud <= BIT_RELOAD;
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 4'd0) begin
                            if (rx_sync) rx_state <= RX_IDLE;
                        end else if (rx_bit == 4'd9) begin
                            rx_state <= RX_IDLE;
                            byte_vld <= rx_sync;
                        end else begin
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign cmd_set = (asm_state == ASM_LOW) && byte_vld;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;

    // Clocks spent waiting for the low byte; restarts on every entry to LOW
    always_ff @(posedge clk) begin
        if (rst || asm_state != ASM_LOW) to_cnt <= '0;
        else                             to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (asm_state == ASM_LOW) && (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Byte pairing into commands and the cmd_rdy handshake (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state <= ASM_HIGH;
            high_byte <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            case (asm_state)
                ASM_HIGH: begin
                    if (byte_vld) begin
                        high_byte <= rx_shift;
                        asm_state <= ASM_LOW;
                    end
                end
                ASM_LOW: begin
                    if (byte_vld) begin
                        cmd       <= {high_byte, rx_shift};
                        asm_state <= ASM_HIGH;
                    end else if (timeout) begin
                        asm_state <= ASM_HIGH;
                    end
                end
                default: asm_state <= ASM_HIGH;
            endcase
            if (cmd_set)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || (rx_start && asm_state == ASM_HIGH))
                cmd_rdy <= 1'b0;
        end
    end

    // TX is bit 0 of the shift register, so the line is driven straight from a flop
    assign TX = tx_shift[0];

    // Transmitter: one 10-bit frame per accepted trmt, trmt ignored while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift <= {1'b1, resp, 1'b0};
                        tx_baud  <= BIT_RELOAD;
                        tx_bit   <= '0;
                        tx_done  <= 1'b0;
                        tx_state <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_baud != '0) begin
                        tx_baud <= tx_baud - 1'b1;
                    end else if (tx_bit == 4'd9) begin
                        tx_shift <= '1;
                        tx_done  <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_baud  <= BIT_RELOAD;
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed testbench for uart_cmd_responder (BAUD_DIV=16, TIMEOUT_CYC=400).
// Expected cmd_rdy rise is 156 clk after the second byte's start edge:
// 2 sync + 8 half-bit + 9*16 bits + 1 byte-valid + 1 register.
module tb_uart_cmd_responder;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    int checks = 0;
    int passes = 0;
    int rise_at;
    int fall_at;

    uart_cmd_responder #(.BAUD_DIV(B), .TIMEOUT_CYC(400)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Drive one UART frame starting at a falling edge; records cmd_rdy edges
    task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at);
        logic [9:0] fr;
        logic       last;
        fr = {stop, b, 1'b0};
        rise_at = -1;
        fall_at = -1;
        last = cmd_rdy;
        for (int i = 0; i < 10 * B; i++) begin
            RX = fr[i / B];
            clr_cmd_rdy = (i == clr_at);
            @(negedge clk);
            if (cmd_rdy && !last && rise_at < 0) rise_at = i + 1;
            if (!cmd_rdy && last && fall_at < 0) fall_at = i + 1;
            last = cmd_rdy;
        end
        clr_cmd_rdy = 1'b0;
        RX = 1'b1;
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    // Pulse trmt and check each bit at its centre plus tx_done timing
    task automatic tx_frame(input logic [7:0] r, input logic [9:0] exp_bits, input logic inject);
        trmt = 1'b1;
        resp = r;
        @(negedge clk);
        trmt = 1'b0;
        for (int m = 1; m <= 10 * B + 1; m++) begin
            if (m == 1) begin
                checks++; if (tx_done !== 1'b0) $display("FAIL tx_done_clr: got %b expected 0", tx_done); else passes++;
            end
            if ((m - 1) % B == B / 2) begin
                checks++;
                if (TX !== exp_bits[(m - 1) / B]) $display("FAIL tx_bit%0d: got %b expected %b", (m - 1) / B, TX, exp_bits[(m - 1) / B]);
                else passes++;
            end
            if (m == 10 * B) begin
                checks++; if (tx_done !== 1'b0) $display("FAIL tx_done_early: got %b expected 0", tx_done); else passes++;
            end
            if (m == 10 * B + 1) begin
                checks++; if (tx_done !== 1'b1) $display("FAIL tx_done_set: got %b expected 1", tx_done); else passes++;
                checks++; if (TX !== 1'b1) $display("FAIL tx_idle: got %b expected 1", TX); else passes++;
            end
            if (m < 10 * B + 1) begin
                trmt = inject && (m == 5 * B + 3);
                if (inject && m == 5 * B + 3) resp = 8'h5A;
                @(negedge clk);
            end
        end
        trmt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (TX !== 1'b1) $display("FAIL rst_tx: got %b expected 1", TX); else passes++;
            checks++; if (cmd_rdy !== 1'b0) $display("FAIL rst_cmd_rdy: got %b expected 0", cmd_rdy); else passes++;
            checks++; if (tx_done !== 1'b0) $display("FAIL rst_tx_done: got %b expected 0", tx_done); else passes++;
            checks++; if (cmd !== 16'h0000) $display("FAIL rst_cmd: got %h expected 0000", cmd); else passes++;
        end
    endtask

    task automatic test_cmd_rx();
        send_byte(8'h20, 1'b1, -1);
        checks++; if (cmd_rdy !== 1'b0) $display("FAIL half_cmd_rdy: got %b expected 0", cmd_rdy); else passes++;
        send_byte(8'h00, 1'b1, -1);
        checks++; if (rise_at !== 156) $display("FAIL rdy_latency: got %0d expected 156", rise_at); else passes++;
        checks++; if (cmd !== 16'h2000) $display("FAIL cmd_2000: got %h expected 2000", cmd); else passes++;
        clear_rdy();
        checks++; if (cmd_rdy !== 1'b0) $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); else passes++;
        checks++; if (cmd !== 16'h2000) $display("FAIL cmd_hold: got %h expected 2000", cmd); else passes++;
    endtask

    task automatic test_tx();
        tx_frame(8'hA5, 10'b1101001010, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (tx_done !== 1'b1) $display("FAIL tx_done_hold: got %b expected 1", tx_done); else passes++;
        checks++; if (TX !== 1'b1) $display("FAIL tx_no_retx: got %b expected 1", TX); else passes++;
        tx_frame(8'h5A, 10'b1010110100, 1'b0);
    endtask

    task automatic test_overwrite();
        send_byte(8'h40, 1'b1, -1);
        send_byte(8'h22, 1'b1, -1);
        checks++; if (cmd !== 16'h4022) $display("FAIL cmd_4022: got %h expected 4022", cmd); else passes++;
        send_byte(8'h43, 1'b1, -1);
        checks++; if (fall_at !== 3) $display("FAIL rdy_drop_at_start: got %0d expected 3", fall_at); else passes++;
        checks++; if (cmd !== 16'h4022) $display("FAIL cmd_stable: got %h expected 4022", cmd); else passes++;
        send_byte(8'hF1, 1'b1, 155);
        checks++; if (rise_at !== 156) $display("FAIL set_vs_clr_edge: got %0d expected 156", rise_at); else passes++;
        checks++; if (cmd !== 16'h43F1) $display("FAIL cmd_43f1: got %h expected 43f1", cmd); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL set_wins: got %b expected 1", cmd_rdy); else passes++;
        clear_rdy();
    endtask

    task automatic test_errors();
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h99, 1'b0, -1);
        checks++; if (rise_at !== -1) $display("FAIL frame_err_rdy: got %0d expected -1", rise_at); else passes++;
        checks++; if (cmd !== 16'h43F1) $display("FAIL frame_err_cmd: got %h expected 43f1", cmd); else passes++;
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (12 * B) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) $display("FAIL glitch_rdy: got %b expected 0", cmd_rdy); else passes++;
        checks++; if (cmd !== 16'h43F1) $display("FAIL glitch_cmd: got %h expected 43f1", cmd); else passes++;
        RX = 1'b0;
        repeat (3 * B) @(negedge clk);
        rst = 1'b1;
        RX = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (cmd !== 16'h0000) $display("FAIL midrst_cmd: got %h expected 0000", cmd); else passes++;
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b1, -1);
        checks++; if (cmd !== 16'h1234) $display("FAIL cmd_1234: got %h expected 1234", cmd); else passes++;
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL rdy_1234: got %b expected 1", cmd_rdy); else passes++;
        clear_rdy();
    endtask

    task automatic test_full_duplex();
        fork
            begin
                send_byte(8'h5A, 1'b1, -1);
                send_byte(8'hC3, 1'b1, -1);
            end
            tx_frame(8'h3C, 10'b1001111000, 1'b0);
        join
        checks++; if (cmd !== 16'h5AC3) $display("FAIL duplex_cmd: got %h expected 5ac3", cmd); else passes++;
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL duplex_rdy: got %b expected 1", cmd_rdy); else passes++;
        clear_rdy();
    endtask

    task automatic test_timeout();
        logic [15:0] exp_cmd;
        logic        exp_rdy;
`ifdef CMD_TIMEOUT_EN
        exp_cmd = 16'h4002;
        exp_rdy = 1'b1;
`else
        exp_cmd = 16'h5540;
        exp_rdy = 1'b0;
`endif
        send_byte(8'h55, 1'b1, -1);
        repeat (600) @(negedge clk);
        send_byte(8'h40, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        checks++; if (cmd !== exp_cmd) $display("FAIL timeout_cmd: got %h expected %h", cmd, exp_cmd); else passes++;
        checks++; if (cmd_rdy !== exp_rdy) $display("FAIL timeout_rdy: got %b expected %b", cmd_rdy, exp_rdy); else passes++;
    endtask

    initial begin
        test_reset();
        test_cmd_rx();
        test_tx();
        test_overwrite();
        test_errors();
        test_full_duplex();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
